multicrack_ctrl: RTL and testbench

//  Arbitration/copy controller for N parallel ARC4 brute-force crack engines (N-way successor to the two-engine wrapper).

---
 rtl/crack_pkg.sv | 28 ++
 rtl/prio_arb.sv | 18 +
 rtl/multicrack_ctrl.sv | 167 ++++++++++++++++
 tb/tb_multicrack_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// Shared types and helpers for the multi-engine ARC4 crack controller.
package crack_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        RD,
        WR,
        DONE
    } state_t;

    localparam int KEY_W_DEF   = 24;
    localparam int ADDR_W_DEF  = 8;
    localparam int MAX_ENGINES = 16;

    // Lowest set bit wins; scanning downward lets the lowest index overwrite last.
    function automatic logic [3:0] prio_enc(input logic [MAX_ENGINES-1:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = MAX_ENGINES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_arb.sv
// Fixed-priority arbiter: lowest-index request wins, reported as index and one-hot.
module prio_arb
    import crack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic             any,
    output logic [IDX_W-1:0] index,
    output logic [WIDTH-1:0] onehot
);

    assign any    = |req;
    assign index  = IDX_W'(prio_enc(MAX_ENGINES'(req)));
    assign onehot = req & (~req + 1'b1);

endmodule

// File: rtl/multicrack_ctrl.sv
// Starts N crack engines, picks the first (lowest-index) engine with a valid key,
// aborts the rest and copies the winner's length-prefixed plaintext into pt_mem.
module multicrack_ctrl
    import crack_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int KEY_W       = KEY_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    output logic                           rdy,
    output logic [KEY_W-1:0]               key,
    output logic                           key_valid,
    output logic                           search_fail,
    output logic [$clog2(NUM_ENGINES)-1:0] winner,
    output logic [NUM_ENGINES-1:0]         eng_en,
    output logic [NUM_ENGINES-1:0]         eng_abort,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    input  logic [NUM_ENGINES-1:0]         eng_key_valid,
    input  logic [NUM_ENGINES*KEY_W-1:0]   eng_key,
    output logic [ADDR_W-1:0]              eng_pt_addr,
    input  logic [NUM_ENGINES*8-1:0]       eng_pt_rddata,
    output logic [ADDR_W-1:0]              pt_addr,
    output logic [7:0]                     pt_wrdata,
    output logic                           pt_wren
);

    localparam int IDX_W = $clog2(NUM_ENGINES);

    state_t                 state_q, state_d;
    logic                   rdy_q, rdy_d;
    logic [KEY_W-1:0]       key_q, key_d;
    logic                   key_valid_q, key_valid_d;
    logic                   search_fail_q, search_fail_d;
    logic [IDX_W-1:0]       winner_q, winner_d;
    logic [NUM_ENGINES-1:0] eng_en_q, eng_en_d;
    logic [NUM_ENGINES-1:0] eng_abort_q, eng_abort_d;
    logic [ADDR_W-1:0]      idx_q, idx_d;
    logic [ADDR_W-1:0]      len_q, len_d;

    logic [NUM_ENGINES-1:0] hit;
    logic                   hit_any;
    logic [IDX_W-1:0]       hit_idx;
    logic [NUM_ENGINES-1:0] hit_onehot;
    logic [7:0]             cur_byte;
    logic [ADDR_W-1:0]      cur_len;

    assign hit = eng_done & eng_key_valid;

    prio_arb #(
        .WIDTH (NUM_ENGINES),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (hit),
        .any    (hit_any),
        .index  (hit_idx),
        .onehot (hit_onehot)
    );

    // Byte 0 of the message is its length, so on the first write it must be
    // used directly because len_q is only loaded at the end of that cycle.
    assign cur_byte = eng_pt_rddata[winner_q*8 +: 8];
    assign cur_len  = (idx_q == '0) ? ADDR_W'(cur_byte) : len_q;

    always_comb begin
        state_d       = state_q;
        rdy_d         = rdy_q;
        key_d         = key_q;
        key_valid_d   = key_valid_q;
        search_fail_d = search_fail_q;
        winner_d      = winner_q;
        eng_en_d      = '0;
        eng_abort_d   = eng_abort_q;
        idx_d         = idx_q;
        len_d         = len_q;

        case (state_q)
            IDLE, DONE: begin
                if (en) begin
                    state_d       = SEARCH;
                    rdy_d         = 1'b0;
                    eng_en_d      = '1;
                    eng_abort_d   = '0;
                    key_valid_d   = 1'b0;
                    search_fail_d = 1'b0;
                end
            end
            SEARCH: begin
                if (hit_any) begin
                    state_d     = RD;
                    winner_d    = hit_idx;
                    key_d       = eng_key[hit_idx*KEY_W +: KEY_W];
                    eng_abort_d = ~hit_onehot;
                    idx_d       = '0;
                end else if (&eng_done) begin
                    state_d       = DONE;
                    search_fail_d = 1'b1;
                    rdy_d         = 1'b1;
                end
            end
            RD: begin
                state_d = WR;
            end
            WR: begin
                if (idx_q == '0) begin
                    len_d = cur_len;
                end
                // Compare before incrementing so a 255-byte message never wraps idx.
                if (idx_q == cur_len) begin
                    state_d     = DONE;
                    key_valid_d = 1'b1;
                    rdy_d       = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rdy_q         <= 1'b1;
            key_q         <= '0;
            key_valid_q   <= 1'b0;
            search_fail_q <= 1'b0;
            winner_q      <= '0;
            eng_en_q      <= '0;
            eng_abort_q   <= '0;
            idx_q         <= '0;
            len_q         <= '0;
        end else begin
            state_q       <= state_d;
            rdy_q         <= rdy_d;
            key_q         <= key_d;
            key_valid_q   <= key_valid_d;
            search_fail_q <= search_fail_d;
            winner_q      <= winner_d;
            eng_en_q      <= eng_en_d;
            eng_abort_q   <= eng_abort_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
        end
    end

    // The read address is held through RD and WR so the synchronous read data
    // lines up with the WR cycle; the write strobe is masked while reset is low.
    assign eng_pt_addr = idx_q;
    assign pt_addr     = idx_q;
    assign pt_wrdata   = cur_byte;
    assign pt_wren     = (state_q == WR) && rst_n;

    assign rdy         = rdy_q;
    assign key         = key_q;
    assign key_valid   = key_valid_q;
    assign search_fail = search_fail_q;
    assign winner      = winner_q;
    assign eng_en      = eng_en_q;
    assign eng_abort   = eng_abort_q;

endmodule

// File: tb/tb_multicrack_ctrl.sv
// Directed self-checking bench for multicrack_ctrl with four modelled engines.
module tb_multicrack_ctrl;

    localparam int N  = 4;
    localparam int KW = 24;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          rdy;
    logic [KW-1:0] key;
    logic          key_valid;
    logic          search_fail;
    logic [1:0]    winner;
    logic [N-1:0]  eng_en;
    logic [N-1:0]  eng_abort;
    logic [N-1:0]  eng_done = '0;
    logic [N-1:0]  eng_key_valid = '0;
    logic [N*KW-1:0] eng_key = {24'h3C3C03, 24'h00000A, 24'h1B1B01, 24'h0F0F00};
    logic [AW-1:0] eng_pt_addr;
    logic [N*8-1:0] eng_pt_rddata = '0;
    logic [AW-1:0] pt_addr;
    logic [7:0]    pt_wrdata;
    logic          pt_wren;

    logic [7:0] eng_mem [N][256];
    int         msg_len [N];
    logic [7:0] wr_addr [$];
    logic [7:0] wr_data [$];
    int         n_vec = 0;
    int         n_err = 0;

    multicrack_ctrl #(
        .NUM_ENGINES (N),
        .KEY_W       (KW),
        .ADDR_W      (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .rdy           (rdy),
        .key           (key),
        .key_valid     (key_valid),
        .search_fail   (search_fail),
        .winner        (winner),
        .eng_en        (eng_en),
        .eng_abort     (eng_abort),
        .eng_done      (eng_done),
        .eng_key_valid (eng_key_valid),
        .eng_key       (eng_key),
        .eng_pt_addr   (eng_pt_addr),
        .eng_pt_rddata (eng_pt_rddata),
        .pt_addr       (pt_addr),
        .pt_wrdata     (pt_wrdata),
        .pt_wren       (pt_wren)
    );

    always #5 clk = ~clk;

    // Engine plaintext memories with one cycle of read latency.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            eng_pt_rddata[i*8 +: 8] <= eng_mem[i][eng_pt_addr];
        end
    end

    function automatic logic [7:0] byte_of(input int e, input int k);
        if (k == 0) return 8'(msg_len[e]);
        return 8'((e << 6) ^ k ^ 8'h33);
    endfunction

    task automatic fill_memories();
        msg_len[0] = 255;
        msg_len[1] = 3;
        msg_len[2] = 5;
        msg_len[3] = 7;
        for (int e = 0; e < N; e++) begin
            for (int k = 0; k < 256; k++) begin
                eng_mem[e][k] = byte_of(e, k);
            end
        end
    endtask

    task automatic start_run(output logic [N-1:0] pulse, output logic rdy_seen,
                             output logic kv_seen);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        pulse    = eng_en;
        rdy_seen = rdy;
        kv_seen  = key_valid;
        en = 1'b0;
    endtask

    task automatic collect_copy(input int budget, output int cycles, output bit timed_out);
        wr_addr.delete();
        wr_data.delete();
        cycles    = 0;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            cycles++;
            if (pt_wren) begin
                wr_addr.push_back(pt_addr);
                wr_data.push_back(pt_wrdata);
            end
            if (rdy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (rdy !== 1'b1) begin n_err++; $display("[TB] FAIL reset_rdy: got %b want 1", rdy); end
        n_vec++; if (key !== 24'h0) begin n_err++; $display("[TB] FAIL reset_key: got %h want 0", key); end
        n_vec++; if ({key_valid, search_fail, pt_wren} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_flags: got %b want 000", {key_valid, search_fail, pt_wren}); end
        n_vec++; if ({winner, eng_en, eng_abort} !== 10'h0) begin n_err++; $display("[TB] FAIL reset_eng: got %h want 0", {winner, eng_en, eng_abort}); end
        n_vec++; if ({pt_addr, eng_pt_addr} !== 16'h0) begin n_err++; $display("[TB] FAIL reset_addr: got %h want 0", {pt_addr, eng_pt_addr}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_hit();
        logic [N-1:0] pulse;
        logic r, kv;
        int cyc;
        bit to;
        int bad;
        start_run(pulse, r, kv);
        n_vec++; if (pulse !== 4'b1111) begin n_err++; $display("[TB] FAIL start_pulse: got %b want 1111", pulse); end
        n_vec++; if (r !== 1'b0) begin n_err++; $display("[TB] FAIL start_rdy: got %b want 0", r); end
        @(negedge clk);
        n_vec++; if (eng_en !== 4'b0000) begin n_err++; $display("[TB] FAIL pulse_width: got %b want 0000", eng_en); end
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n_vec++; if (eng_en !== 4'b0000) begin n_err++; $display("[TB] FAIL en_while_busy: got %b want 0000", eng_en); end
        eng_done      = 4'b0100;
        eng_key_valid = 4'b0100;
        @(negedge clk);
        n_vec++; if (winner !== 2'd2) begin n_err++; $display("[TB] FAIL t1_winner: got %0d want 2", winner); end
        n_vec++; if (key !== 24'h00000A) begin n_err++; $display("[TB] FAIL t1_key: got %h want 00000a", key); end
        n_vec++; if (eng_abort !== 4'b1011) begin n_err++; $display("[TB] FAIL t1_abort: got %b want 1011", eng_abort); end
        collect_copy(100, cyc, to);
        n_vec++; if (to !== 1'b0) begin n_err++; $display("[TB] FAIL t1_timeout: got %b want 0", to); end
        n_vec++; if (wr_addr.size() !== 6) begin n_err++; $display("[TB] FAIL t1_writes: got %0d want 6", wr_addr.size()); end
        bad = 0;
        for (int k = 0; k < wr_addr.size(); k++) begin
            if (wr_addr[k] !== 8'(k) || wr_data[k] !== byte_of(2, k)) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("[TB] FAIL t1_data: got %0d bad bytes want 0", bad); end
        n_vec++; if (cyc !== 12) begin n_err++; $display("[TB] FAIL t1_latency: got %0d want 12", cyc); end
        n_vec++; if ({key_valid, search_fail, eng_abort} !== 6'b10_1011) begin n_err++; $display("[TB] FAIL t1_done: got %b want 101011", {key_valid, search_fail, eng_abort}); end
    endtask

    task automatic test_simultaneous_hit();
        logic [N-1:0] pulse;
        logic r, kv;
        int cyc;
        bit to;
        int bad;
        eng_done      = 4'b0000;
        eng_key_valid = 4'b0000;
        start_run(pulse, r, kv);
        eng_done      = 4'b1010;
        eng_key_valid = 4'b1010;
        @(negedge clk);
        eng_key_valid = 4'b1000;
        n_vec++; if (winner !== 2'd1) begin n_err++; $display("[TB] FAIL t2_winner: got %0d want 1", winner); end
        n_vec++; if ({key, eng_abort} !== {24'h1B1B01, 4'b1101}) begin n_err++; $display("[TB] FAIL t2_key_abort: got %h want 1b1b01d", {key, eng_abort}); end
        collect_copy(100, cyc, to);
        n_vec++; if (wr_addr.size() !== 4) begin n_err++; $display("[TB] FAIL t2_writes: got %0d want 4", wr_addr.size()); end
        bad = 0;
        for (int k = 0; k < wr_data.size(); k++) begin
            if (wr_data[k] !== byte_of(1, k)) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("[TB] FAIL t2_data: got %0d bad bytes want 0", bad); end
        n_vec++; if ({to, winner, key_valid} !== 4'b0011) begin n_err++; $display("[TB] FAIL t2_end: got %b want 0011", {to, winner, key_valid}); end
    endtask

    task automatic test_all_fail();
        logic [N-1:0] pulse;
        logic r, kv;
        int cyc;
        bit to;
        eng_done      = 4'b0000;
        eng_key_valid = 4'b0000;
        start_run(pulse, r, kv);
        n_vec++; if (kv !== 1'b0) begin n_err++; $display("[TB] FAIL t3_kv_cleared: got %b want 0", kv); end
        eng_done = 4'b1111;
        collect_copy(20, cyc, to);
        n_vec++; if (to !== 1'b0) begin n_err++; $display("[TB] FAIL t3_timeout: got %b want 0", to); end
        n_vec++; if (wr_addr.size() !== 0) begin n_err++; $display("[TB] FAIL t3_writes: got %0d want 0", wr_addr.size()); end
        n_vec++; if ({search_fail, key_valid, rdy, eng_abort} !== 7'b101_0000) begin n_err++; $display("[TB] FAIL t3_status: got %b want 1010000", {search_fail, key_valid, rdy, eng_abort}); end
    endtask

    task automatic test_long_message();
        logic [N-1:0] pulse;
        logic r, kv;
        int cyc;
        bit to;
        int bad;
        eng_done      = 4'b0000;
        eng_key_valid = 4'b0000;
        start_run(pulse, r, kv);
        eng_done      = 4'b0001;
        eng_key_valid = 4'b0001;
        @(negedge clk);
        collect_copy(600, cyc, to);
        n_vec++; if (to !== 1'b0) begin n_err++; $display("[TB] FAIL t4_timeout: got %b want 0", to); end
        n_vec++; if (wr_addr.size() !== 256) begin n_err++; $display("[TB] FAIL t4_writes: got %0d want 256", wr_addr.size()); end
        if (wr_addr.size() > 0) begin
            n_vec++; if (wr_addr[wr_addr.size()-1] !== 8'd255) begin n_err++; $display("[TB] FAIL t4_last_addr: got %0d want 255", wr_addr[wr_addr.size()-1]); end
        end
        bad = 0;
        for (int k = 0; k < wr_addr.size(); k++) begin
            if (wr_addr[k] !== 8'(k) || wr_data[k] !== byte_of(0, k)) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("[TB] FAIL t4_data: got %0d bad bytes want 0", bad); end
        n_vec++; if (cyc !== 512) begin n_err++; $display("[TB] FAIL t4_latency: got %0d want 512", cyc); end
        n_vec++; if ({key_valid, key} !== {1'b1, 24'h0F0F00}) begin n_err++; $display("[TB] FAIL t4_key: got %h want 10f0f00", {key_valid, key}); end
    endtask

    task automatic test_reset_mid_copy();
        logic [N-1:0] pulse;
        logic r, kv;
        bit found;
        eng_done      = 4'b0000;
        eng_key_valid = 4'b0000;
        start_run(pulse, r, kv);
        eng_done      = 4'b0001;
        eng_key_valid = 4'b0001;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (pt_wren && pt_addr == 8'd40) begin
                found = 1'b1;
                break;
            end
        end
        n_vec++; if (found !== 1'b1) begin n_err++; $display("[TB] FAIL t5_reach_idx40: got %b want 1", found); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (pt_wren !== 1'b0) begin n_err++; $display("[TB] FAIL t5_wren_in_reset: got %b want 0", pt_wren); end
        @(negedge clk);
        n_vec++; if ({rdy, pt_wren, eng_abort} !== 6'b10_0000) begin n_err++; $display("[TB] FAIL t5_idle: got %b want 100000", {rdy, pt_wren, eng_abort}); end
        n_vec++; if ({key_valid, pt_addr} !== 9'h0) begin n_err++; $display("[TB] FAIL t5_cleared: got %h want 0", {key_valid, pt_addr}); end
        rst_n = 1'b1;
        eng_done      = 4'b0000;
        eng_key_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] pulse;
        logic r, kv;
        int cyc;
        bit to;
        int bad;
        start_run(pulse, r, kv);
        eng_done      = 4'b0100;
        eng_key_valid = 4'b0100;
        collect_copy(100, cyc, to);
        n_vec++; if ({to, key_valid, winner} !== 4'b0110) begin n_err++; $display("[TB] FAIL t6_first_run: got %b want 0110", {to, key_valid, winner}); end
        eng_done      = 4'b0000;
        eng_key_valid = 4'b0000;
        start_run(pulse, r, kv);
        n_vec++; if (pulse !== 4'b1111) begin n_err++; $display("[TB] FAIL t6_pulse: got %b want 1111", pulse); end
        n_vec++; if ({kv, r, eng_abort} !== 6'b00_0000) begin n_err++; $display("[TB] FAIL t6_restart: got %b want 000000", {kv, r, eng_abort}); end
        @(negedge clk);
        n_vec++; if (eng_en !== 4'b0000) begin n_err++; $display("[TB] FAIL t6_pulse_width: got %b want 0000", eng_en); end
        eng_done      = 4'b1000;
        eng_key_valid = 4'b1000;
        @(negedge clk);
        n_vec++; if ({winner, eng_abort, key} !== {2'd3, 4'b0111, 24'h3C3C03}) begin n_err++; $display("[TB] FAIL t6_winner: got %h want 373c3c03", {winner, eng_abort, key}); end
        collect_copy(100, cyc, to);
        bad = 0;
        for (int k = 0; k < wr_data.size(); k++) begin
            if (wr_addr[k] !== 8'(k) || wr_data[k] !== byte_of(3, k)) bad++;
        end
        n_vec++; if ({wr_addr.size(), bad} !== {32'd8, 32'd0}) begin n_err++; $display("[TB] FAIL t6_copy: got %0d writes %0d bad want 8 writes 0 bad", wr_addr.size(), bad); end
        n_vec++; if ({to, key_valid, search_fail, rdy} !== 4'b0101) begin n_err++; $display("[TB] FAIL t6_done: got %b want 0101", {to, key_valid, search_fail, rdy}); end
    endtask

    initial begin
        fill_memories();
        test_reset();
        test_single_hit();
        test_simultaneous_hit();
        test_all_fail();
        test_long_message();
        test_reset_mid_copy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
